// File: rtl/brlshft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : brlshft_ctrl
// Purpose  : Round-robin arbitration and multi-pass sequencing for a shared,
//            external, combinational 4-bit barrel shifter. Each accepted
//            command is applied rpt+1 times, the shifter result feeding back
//            as the next operand; the final value is returned with a
//            one-cycle done pulse tagged with the owning requester.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req/cmd/data/rpt0,1 - requester command channels
//            gnt0, gnt1          - accept pulses (combinational, IDLE only)
//            sh_l_r/rot/sv1/sv0  - shifter controls, stable through RUN
//            sh_in, sh_out       - shifter operand / result
//            busy, done, done_id - status and completion pulse with owner
//            res                 - result, held until the next done
// Revision : 1.0 - initial release
// ============================================================================
module brlshft_ctrl #(
    parameter int RPT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       cmd0,
    input  logic [3:0]       cmd1,
    input  logic [3:0]       data0,
    input  logic [3:0]       data1,
    input  logic [RPT_W-1:0] rpt0,
    input  logic [RPT_W-1:0] rpt1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sh_l_r,
    output logic             sh_rot,
    output logic             sh_sv1,
    output logic             sh_sv0,
    output logic [3:0]       sh_in,
    input  logic [3:0]       sh_out,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [3:0]       res
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_ptr;
    logic [3:0]       r_acc;
    logic [RPT_W-1:0] r_cnt;
    logic             r_own;
    logic [3:0]       r_res;
    logic             r_done_id;
    logic [3:0]       r_ctrl;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_last;

    assign w_last = (r_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_gnt0 || w_gnt1) w_next = c_S_RUN;
            c_S_RUN:  if (w_last)           w_next = c_S_DONE;
            c_S_DONE:                       w_next = c_S_IDLE;
            default:                        w_next = c_S_IDLE;
        endcase
    end

    // Output logic. Grants are masked by rst so nothing is accepted on an
    // edge that is about to reset the datapath.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_gnt0 = !rst && req0 && (!req1 || !r_ptr);
                w_gnt1 = !rst && req1 && (!req0 ||  r_ptr);
            end
            c_S_RUN: begin
                busy = 1'b1;
            end
            c_S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: command capture, iterative feedback and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 1'b0;
            r_acc     <= 4'd0;
            r_cnt     <= '0;
            r_own     <= 1'b0;
            r_res     <= 4'd0;
            r_done_id <= 1'b0;
            r_ctrl    <= 4'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_gnt0) begin
                        r_ctrl <= cmd0;
                        r_acc  <= data0;
                        r_cnt  <= rpt0;
                        r_own  <= 1'b0;
                        r_ptr  <= 1'b1;
                    end else if (w_gnt1) begin
                        r_ctrl <= cmd1;
                        r_acc  <= data1;
                        r_cnt  <= rpt1;
                        r_own  <= 1'b1;
                        r_ptr  <= 1'b0;
                    end
                end
                c_S_RUN: begin
                    r_acc <= sh_out;
                    // The final pass result goes straight into res so that it
                    // changes exactly on entry to DONE.
                    if (w_last) begin
                        r_res     <= sh_out;
                        r_done_id <= r_own;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign sh_l_r  = r_ctrl[3];
    assign sh_rot  = r_ctrl[2];
    assign sh_sv1  = r_ctrl[1];
    assign sh_sv0  = r_ctrl[0];
    assign sh_in   = r_acc;
    assign res     = r_res;
    assign done_id = r_done_id;

endmodule
`default_nettype wire

// File: tb/tb_brlshft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_brlshft_ctrl
// Purpose  : Directed self-checking bench for brlshft_ctrl with a behavioural
//            4-bit barrel shifter closing the sh_* / sh_out loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brlshft_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] cmd0, cmd1, data0, data1;
    logic [2:0] rpt0, rpt1;
    logic       gnt0, gnt1;
    logic       sh_l_r, sh_rot, sh_sv1, sh_sv0;
    logic [3:0] sh_in, sh_out;
    logic       busy, done, done_id;
    logic [3:0] res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brlshft_ctrl #(.RPT_W(3)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .cmd0(cmd0), .cmd1(cmd1),
        .data0(data0), .data1(data1),
        .rpt0(rpt0), .rpt1(rpt1),
        .gnt0(gnt0), .gnt1(gnt1),
        .sh_l_r(sh_l_r), .sh_rot(sh_rot), .sh_sv1(sh_sv1), .sh_sv0(sh_sv0),
        .sh_in(sh_in), .sh_out(sh_out),
        .busy(busy), .done(done), .done_id(done_id), .res(res)
    );

    // Behavioural barrel shifter
    always_comb begin
        logic [7:0] w_dd;
        logic [7:0] w_l;
        logic [7:0] w_r;
        logic [1:0] w_sv;
        w_sv   = {sh_sv1, sh_sv0};
        w_dd   = {sh_in, sh_in};
        w_l    = w_dd << w_sv;
        w_r    = w_dd >> w_sv;
        sh_out = 4'd0;
        if (sh_rot) sh_out = sh_l_r ? w_l[7:4] : w_r[3:0];
        else        sh_out = sh_l_r ? (sh_in << w_sv) : (sh_in >> w_sv);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One command from a lone requester, checked cycle by cycle.
    task automatic run_cmd(input bit id, input logic [3:0] c, input logic [3:0] d,
                           input logic [2:0] r, input logic [3:0] exp);
        if (id == 1'b0) begin req0 = 1'b1; cmd0 = c; data0 = d; rpt0 = r; end
        else            begin req1 = 1'b1; cmd1 = c; data1 = d; rpt1 = r; end
        #1;
        chk("gnt0", gnt0, (id == 1'b0));
        chk("gnt1", gnt1, (id == 1'b1));
        chk("busy_idle", busy, 0);
        tick;
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i <= int'(r); i++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("gnt_run", {gnt1, gnt0}, 0);
            chk("sh_ctrl", {sh_l_r, sh_rot, sh_sv1, sh_sv0}, c);
            tick;
        end
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("res", res, exp);
        chk("done_id", done_id, id);
        tick;
        chk("done_clr", done, 0);
        chk("busy_clr", busy, 0);
        chk("res_hold", res, exp);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        cmd0 = 4'd0; cmd1 = 4'd0; data0 = 4'd0; data1 = 4'd0;
        rpt0 = 3'd0; rpt1 = 3'd0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_res", res, 0);
        chk("rst_sh_in", sh_in, 0);
        chk("rst_sh_ctrl", {sh_l_r, sh_rot, sh_sv1, sh_sv0}, 0);
        tick;

        run_cmd(1'b0, 4'b1101, 4'b1001, 3'd0, 4'b0011); // rotl 1
        run_cmd(1'b0, 4'b1101, 4'b1001, 3'd3, 4'b1001); // rotl 1 x4
        run_cmd(1'b1, 4'b0001, 4'b1000, 3'd2, 4'b0001); // lsr 1 x3
        run_cmd(1'b1, 4'b1011, 4'b1111, 3'd0, 4'b1000); // lsl 3
        run_cmd(1'b0, 4'b0110, 4'b1100, 3'd1, 4'b1100); // ror 2 x2

        // Both requesters held from reset: grants alternate 0,1,0,1.
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        cmd0 = 4'b0000; cmd1 = 4'b0000; data0 = 4'b0101; data1 = 4'b0101;
        rpt0 = 3'd0; rpt1 = 3'd0;
        #1;
        chk("gnt_in_rst", {gnt1, gnt0}, 0);
        tick;
        rst = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk("rr_gnt0", gnt0, (c % 3 == 0) && ((c / 3) % 2 == 0));
            chk("rr_gnt1", gnt1, (c % 3 == 0) && ((c / 3) % 2 == 1));
            chk("rr_done", done, (c % 3 == 2));
            if (c % 3 == 2) chk("rr_done_id", done_id, (c / 3) % 2);
            tick;
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("rr_res", res, 4'b0101);

        // Reset in the second RUN cycle abandons the command.
        req0 = 1'b1; cmd0 = 4'b1101; data0 = 4'b0001; rpt0 = 3'd3;
        #1;
        chk("ab_gnt0", gnt0, 1);
        tick;
        req0 = 1'b0;
        tick;
        rst = 1'b1;
        req1 = 1'b1; cmd1 = 4'b0000; data1 = 4'b0110; rpt1 = 3'd0;
        #1;
        chk("ab_gnt_rst", {gnt1, gnt0}, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_res", res, 0);
        chk("ab_done_id", done_id, 0);
        chk("ab_sh_ctrl", {sh_l_r, sh_rot, sh_sv1, sh_sv0}, 0);
        chk("ab_gnt1", {gnt1, gnt0}, 2'b10);
        tick;
        req1 = 1'b0;
        chk("ab_run_done", done, 0);
        tick;
        chk("ab_done2", done, 1);
        chk("ab_res2", res, 4'b0110);
        chk("ab_done_id2", done_id, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
